// File: rtl/packet_ingress_fifo.sv
// packet_ingress_fifo
//   Show-ahead circular beat buffer between the Avalon-ST receive MAC and the
//   sniffer core. It enforces sop/eop framing and keeps a saturating count of
//   framing violations.
//   Optional build macro DROP_ERROR_PKT_EN: writes are speculative until a clean
//   eop commits them. Packets ending in error, and packets larger than DEPTH,
//   are dropped before any reader can see them.
module packet_ingress_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [1:0]        in_empty,
    input  logic              in_error,
    output logic              in_ready,
    input  logic              rdreq,
    output logic [31:0]       rd_data,
    output logic              rd_sop,
    output logic              rd_eop,
    output logic              rd_error,
    output logic [1:0]        rd_empty,
    output logic              rdempty,
    output logic [ADDR_W:0]   occupancy,
    output logic [15:0]       framing_errs
);

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        error;
    } entry_t;

    typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_e;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);

    entry_t            mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, base_ptr;
    logic [ADDR_W:0]   stored_q, stored_d, base_cnt, readable;
    logic [15:0]       errs_q, errs_d;
    logic              accept, pop, wr_en, err_inc, overflow;
    entry_t            wr_entry, head;

`ifdef DROP_ERROR_PKT_EN
    logic [ADDR_W-1:0] cm_ptr_q, cm_ptr_d;
    logic [ADDR_W:0]   cm_cnt_q, cm_cnt_d;
    logic              rewind, commit;

    // Readers see only committed entries. DISCARD swallows beats unconditionally.
    assign readable = cm_cnt_q;
    assign in_ready = (state_q == DISCARD) || (stored_q < FULL_CNT);
    assign overflow = (state_q == IN_PKT) && (stored_q == FULL_CNT) && (cm_cnt_q == '0);
`else
    assign readable = stored_q;
    assign in_ready = (stored_q < FULL_CNT);
    assign overflow = 1'b0;
`endif

    assign accept   = in_valid && in_ready;
    assign rdempty  = (readable == '0);
    assign pop      = rdreq && !rdempty;

    // The error flag only has meaning on the eop beat.
    assign wr_entry = '{data: in_data, sop: in_sop, eop: in_eop,
                        empty: in_empty, error: in_eop && in_error};

    assign head         = mem_q[rd_ptr_q];
    assign rd_data      = rdempty ? '0 : head.data;
    assign rd_sop       = rdempty ? 1'b0 : head.sop;
    assign rd_eop       = rdempty ? 1'b0 : head.eop;
    assign rd_empty     = rdempty ? '0 : head.empty;
    assign rd_error     = rdempty ? 1'b0 : head.error;
    assign occupancy    = readable;
    assign framing_errs = errs_q;

    // State and pointer registers, cleared asynchronously so no partial packet survives.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            stored_q <= '0;
            errs_q   <= '0;
`ifdef DROP_ERROR_PKT_EN
            cm_ptr_q <= '0;
            cm_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            stored_q <= stored_d;
            errs_q   <= errs_d;
`ifdef DROP_ERROR_PKT_EN
            cm_ptr_q <= cm_ptr_d;
            cm_cnt_q <= cm_cnt_d;
`endif
        end
    end

    // Beat storage is written at the (possibly rewound) write position.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; occupancy gates every read, so stale contents are never visible.
        if (wr_en) mem_q[base_ptr] <= wr_entry;
    end

    // Framing FSM next state.
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && in_sop && !in_eop) state_d = IN_PKT;
            IN_PKT:  if (overflow) state_d = DISCARD;
                     else if (accept && in_eop) state_d = IDLE;
            DISCARD: if (accept && in_eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Framing FSM outputs: write enable, error count, and rewind/commit control.
    always_comb begin
        wr_en   = 1'b0;
        err_inc = 1'b0;
`ifdef DROP_ERROR_PKT_EN
        rewind  = 1'b0;
        commit  = 1'b0;
`endif
        case (state_q)
            IDLE: if (accept) begin
                if (in_sop) begin
`ifdef DROP_ERROR_PKT_EN
                    // A single-beat packet that ends in error is never written at all.
                    wr_en  = !(in_eop && in_error);
                    commit = in_eop && !in_error;
`else
                    wr_en  = 1'b1;
`endif
                end else begin
                    err_inc = 1'b1;
                end
            end
            IN_PKT: begin
`ifdef DROP_ERROR_PKT_EN
                if (overflow) begin
                    rewind  = 1'b1;
                    err_inc = 1'b1;
                end else if (accept) begin
                    err_inc = in_sop;
                    rewind  = in_sop || (in_eop && in_error);
                    wr_en   = !(in_eop && in_error);
                    commit  = in_eop && !in_error;
                end
`else
                if (accept) begin
                    wr_en   = 1'b1;
                    err_inc = in_sop;
                end
`endif
            end
            default: ;  // DISCARD consumes beats without storing them
        endcase
    end

    // Pointer, count and error-counter arithmetic.
    always_comb begin
`ifdef DROP_ERROR_PKT_EN
        base_ptr = rewind ? cm_ptr_q : wr_ptr_q;
        base_cnt = rewind ? cm_cnt_q : stored_q;
`else
        base_ptr = wr_ptr_q;
        base_cnt = stored_q;
`endif
        wr_ptr_d = wr_en ? base_ptr + PTR_ONE : base_ptr;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        stored_d = base_cnt + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, pop};
`ifdef DROP_ERROR_PKT_EN
        cm_ptr_d = commit ? wr_ptr_d : cm_ptr_q;
        cm_cnt_d = commit ? stored_d : cm_cnt_q - {{ADDR_W{1'b0}}, pop};
`endif
        errs_d   = (err_inc && (errs_q != 16'hFFFF)) ? errs_q + 16'd1 : errs_q;
    end

endmodule

// File: tb/tb_packet_ingress_fifo.sv
// Directed bench for packet_ingress_fifo (DEPTH=16). Expected values are hand-derived.
`timescale 1ns/1ps
module tb_packet_ingress_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid, in_sop, in_eop, in_error, in_ready;
    logic [1:0]  in_empty;
    logic        rdreq;
    logic [31:0] rd_data;
    logic        rd_sop, rd_eop, rd_error, rdempty;
    logic [1:0]  rd_empty;
    logic [4:0]  occupancy;
    logic [15:0] framing_errs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    packet_ingress_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
        .rdreq(rdreq), .rd_data(rd_data), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .rd_error(rd_error), .rd_empty(rd_empty), .rdempty(rdempty),
        .occupancy(occupancy), .framing_errs(framing_errs)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s,
                         input logic e, input logic [1:0] emp, input logic err);
        in_valid = v; in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_error = err;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        rdreq = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        tick(); tick();
        check("rst_rdempty", 64'(rdempty), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_framing_errs", 64'(framing_errs), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        tick();

`ifndef DROP_ERROR_PKT_EN
        // 3-beat packet: visible the cycle after the first beat, popped in order.
        drive(1'b1, 32'hA000_0001, 1'b1, 1'b0, 2'd0, 1'b0); tick();
        check("pktA_rdempty_beat1", 64'(rdempty), 64'd0);
        check("pktA_head_beat1", 64'(rd_data), 64'hA000_0001);
        check("pktA_sop_beat1", 64'(rd_sop), 64'd1);
        check("pktA_occ_beat1", 64'(occupancy), 64'd1);
        drive(1'b1, 32'hA000_0002, 1'b0, 1'b0, 2'd0, 1'b0); tick();
        drive(1'b1, 32'hA000_0003, 1'b0, 1'b1, 2'd2, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("pktA_occ_full", 64'(occupancy), 64'd3);
        rdreq = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("pktA_rd_data", 64'(rd_data), 64'(32'hA000_0000 + i));
            check("pktA_rd_eop", 64'(rd_eop), 64'(i == 3));
            check("pktA_rd_empty", 64'(rd_empty), (i == 3) ? 64'd2 : 64'd0);
            tick();
        end
        tick();  // rdreq while empty must not underflow
        rdreq = 1'b0;
        check("underflow_occ", 64'(occupancy), 64'd0);
        check("underflow_rdempty", 64'(rdempty), 64'd1);
        check("empty_rd_data_zero", 64'(rd_data), 64'd0);

        // Fill to DEPTH, hold the 17th beat, free one slot, then drain across the wrap.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'hB000_0000 + i, i == 0, 1'b0, 2'd0, 1'b0); tick();
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_occ", 64'(occupancy), 64'd16);
        drive(1'b1, 32'hB000_0010, 1'b0, 1'b1, 2'd0, 1'b0); tick();
        check("held17_occ", 64'(occupancy), 64'd16);
        check("held17_in_ready", 64'(in_ready), 64'd0);
        rdreq = 1'b1;
        check("full_head", 64'(rd_data), 64'hB000_0000);
        tick();
        rdreq = 1'b0;
        check("after_pop_in_ready", 64'(in_ready), 64'd1);
        check("after_pop_occ", 64'(occupancy), 64'd15);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("beat17_accepted_occ", 64'(occupancy), 64'd16);
        rdreq = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("wrap_rd_data", 64'(rd_data), 64'(32'hB000_0000 + i));
            tick();
        end
        rdreq = 1'b0;
        check("wrap_drained", 64'(rdempty), 64'd1);

        // Concurrent push/pop at occupancy 8.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'hC000_0000 + i, i == 0, 1'b0, 2'd0, 1'b0); tick();
        end
        check("conc_occ_start", 64'(occupancy), 64'd8);
        rdreq = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'hC000_0008 + k, 1'b0, k == 19, 2'd0, 1'b0);
            check("conc_rd_data", 64'(rd_data), 64'(32'hC000_0000 + k));
            tick();
            check("conc_occ", 64'(occupancy), 64'd8);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int k = 20; k < 28; k++) begin
            check("conc_drain_data", 64'(rd_data), 64'(32'hC000_0000 + k));
            tick();
        end
        rdreq = 1'b0;
        check("conc_drained", 64'(rdempty), 64'd1);

        // Framing: stray beat in IDLE, then sop in the middle of a packet.
        drive(1'b1, 32'hD000_0000, 1'b0, 1'b0, 2'd0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("stray_not_stored", 64'(rdempty), 64'd1);
        check("stray_errs", 64'(framing_errs), 64'd1);
        drive(1'b1, 32'hE000_0001, 1'b1, 1'b0, 2'd0, 1'b0); tick();
        drive(1'b1, 32'hE000_0002, 1'b0, 1'b0, 2'd0, 1'b0); tick();
        drive(1'b1, 32'hE000_0003, 1'b1, 1'b0, 2'd0, 1'b0); tick();
        drive(1'b1, 32'hE000_0004, 1'b0, 1'b1, 2'd0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("midsop_errs", 64'(framing_errs), 64'd2);
        check("midsop_occ", 64'(occupancy), 64'd4);
        rdreq = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("midsop_rd_data", 64'(rd_data), 64'(32'hE000_0000 + i));
            check("midsop_rd_sop", 64'(rd_sop), 64'(i == 1 || i == 3));
            tick();
        end
        rdreq = 1'b0;

        // Error flag is kept only on the eop beat and passes through.
        drive(1'b1, 32'hF000_0001, 1'b1, 1'b0, 2'd0, 1'b1); tick();
        drive(1'b1, 32'hF000_0002, 1'b0, 1'b1, 2'd1, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("err_occ", 64'(occupancy), 64'd2);
        check("err_nonEop_masked", 64'(rd_error), 64'd0);
        rdreq = 1'b1; tick();
        check("err_eop_data", 64'(rd_data), 64'hF000_0002);
        check("err_eop_flag", 64'(rd_error), 64'd1);
        check("err_eop_empty", 64'(rd_empty), 64'd1);
        tick();
        rdreq = 1'b0;
        check("err_drained", 64'(rdempty), 64'd1);

        // Asynchronous reset in the middle of a packet with 5 entries stored.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h9000_0000 + i, i == 0, 1'b0, 2'd0, 1'b0); tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("pre_rst_occ", 64'(occupancy), 64'd5);
        #2 rst = 1'b1;
        tick();
        check("midrst_rdempty", 64'(rdempty), 64'd1);
        check("midrst_occ", 64'(occupancy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_errs", 64'(framing_errs), 64'd0);
        rst = 1'b0;
        tick();
        drive(1'b1, 32'h9000_0005, 1'b0, 1'b1, 2'd0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("post_rst_no_partial", 64'(rdempty), 64'd1);
        check("post_rst_stray_errs", 64'(framing_errs), 64'd1);
`else
        begin
            int  n_sent;
            int  cyc;
            logic acc;
            // Good packet: hidden until its eop commits.
            drive(1'b1, 32'hA000_0001, 1'b1, 1'b0, 2'd0, 1'b0); tick();
            check("good1_uncommitted", 64'(rdempty), 64'd1);
            drive(1'b1, 32'hA000_0002, 1'b0, 1'b1, 2'd0, 1'b0); tick();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
            check("good1_occ", 64'(occupancy), 64'd2);
            rdreq = 1'b1;
            check("good1_w1", 64'(rd_data), 64'hA000_0001); tick();
            check("good1_w2", 64'(rd_data), 64'hA000_0002); tick();
            rdreq = 1'b0;
            // Bad packet: never becomes readable.
            for (int i = 1; i <= 4; i++) begin
                drive(1'b1, 32'hB000_0000 + i, i == 1, i == 4, 2'd0, i == 4); tick();
                check("bad_rdempty", 64'(rdempty), 64'd1);
            end
            drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0); tick();
            check("bad_dropped_occ", 64'(occupancy), 64'd0);
            // Second good packet.
            for (int i = 1; i <= 3; i++) begin
                drive(1'b1, 32'hC000_0000 + i, i == 1, i == 3, 2'd0, 1'b0); tick();
            end
            drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
            check("good2_occ", 64'(occupancy), 64'd3);
            rdreq = 1'b1;
            for (int i = 1; i <= 3; i++) begin
                check("good2_rd_data", 64'(rd_data), 64'(32'hC000_0000 + i));
                check("good2_rd_error", 64'(rd_error), 64'd0);
                tick();
            end
            rdreq = 1'b0;
            // sop mid-packet rewinds the partial packet.
            drive(1'b1, 32'hD000_0001, 1'b1, 1'b0, 2'd0, 1'b0); tick();
            drive(1'b1, 32'hD000_0002, 1'b0, 1'b0, 2'd0, 1'b0); tick();
            drive(1'b1, 32'hD000_0003, 1'b1, 1'b0, 2'd0, 1'b0); tick();
            drive(1'b1, 32'hD000_0004, 1'b0, 1'b1, 2'd0, 1'b0); tick();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
            check("midsop_errs", 64'(framing_errs), 64'd1);
            check("midsop_occ", 64'(occupancy), 64'd2);
            rdreq = 1'b1;
            check("midsop_w3", 64'(rd_data), 64'hD000_0003); tick();
            check("midsop_w4", 64'(rd_data), 64'hD000_0004); tick();
            rdreq = 1'b0;
            // Oversized 20-beat packet is discarded entirely.
            n_sent = 0;
            cyc    = 0;
            while (n_sent < 20 && cyc < 200) begin
                drive(1'b1, 32'hE000_0000 + n_sent, n_sent == 0, n_sent == 19, 2'd0, 1'b0);
                acc = in_ready;
                tick();
                check("big_rdempty", 64'(rdempty), 64'd1);
                if (acc) n_sent++;
                cyc++;
            end
            check("big_all_beats_taken", 64'(n_sent), 64'd20);
            drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0); tick();
            check("big_occ", 64'(occupancy), 64'd0);
            check("big_errs", 64'(framing_errs), 64'd2);
            check("big_in_ready", 64'(in_ready), 64'd1);
            drive(1'b1, 32'hF000_0001, 1'b1, 1'b1, 2'd3, 1'b0); tick();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
            check("after_big_occ", 64'(occupancy), 64'd1);
            check("after_big_data", 64'(rd_data), 64'hF000_0001);
            check("after_big_empty", 64'(rd_empty), 64'd3);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
